// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector default and the
// {pc, instr} entry that the fetch stage hands to decode.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's external channels: redirect input, instruction
// memory request/response, and the instruction stream toward decode.
interface fetch_unit_if;
  import cpu_pkg::*;

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; valid never waits for ready. The memory response has no ready and is
  // accepted on every posedge where imem_resp_valid is high.
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               if_valid;
  logic               if_ready;
  logic [XLEN-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with push, pop, flush, occupancy and head output.
// A push into a full queue is ignored unless a pop frees a slot that cycle.
module fetch_queue #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches, pairs responses with
// their addresses and buffers them for decode; a redirect squashes everything.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [2:0] MAX_CREDIT = 3'(MAX_OUTSTANDING);

  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop;
  logic [1:0]      pend_count;
  logic [XLEN-1:0] pend_head;
  logic [1:0]      out_count;
  fetch_entry_t    out_head;
  fetch_entry_t    out_push_entry;

  logic       redirect;
  logic       if_pop;
  logic [2:0] credit_used;
  logic       req_valid;
  logic       req_fire;
  logic       resp_take;
  logic       resp_drop;
  logic [2:0] drop_sum;

  assign redirect = bus.redirect_valid;
  assign if_pop   = bus.if_valid && bus.if_ready;

  // An entry leaving toward decode frees its credit in the same cycle, which
  // is what lets a 1-cycle memory sustain one instruction per cycle.
  assign credit_used = 3'(outstanding) + 3'(out_count) + 3'(drop) - 3'(if_pop);
  assign req_valid   = !redirect && (credit_used < MAX_CREDIT);
  assign req_fire    = req_valid && bus.imem_req_ready;

  assign resp_take = bus.imem_resp_valid && !redirect && (drop == 2'd0)
                     && (pend_count != 2'd0);
  assign resp_drop = bus.imem_resp_valid && !redirect && (drop != 2'd0);

  // Requests still in flight at a redirect become responses to discard.
  assign drop_sum = 3'(drop) + 3'(outstanding);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
    end else if (redirect) begin
      fetch_pc    <= align_word(bus.redirect_pc);
      outstanding <= 2'd0;
      if (bus.imem_resp_valid && (drop_sum != 3'd0)) begin
        drop <= 2'(drop_sum - 3'd1);
      end else begin
        drop <= 2'(drop_sum);
      end
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outstanding <= outstanding + 2'(req_fire) - 2'(resp_take);
      drop        <= drop - 2'(resp_drop);
    end
  end

  fetch_queue #(.W(XLEN)) u_pending_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_take),
    .flush     (redirect),
    .count     (pend_count),
    .head      (pend_head)
  );

  assign out_push_entry = '{pc: pend_head, instr: bus.imem_resp_data};

  fetch_queue #(.W($bits(fetch_entry_t))) u_out_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_take),
    .push_data (out_push_entry),
    .pop       (if_pop),
    .flush     (redirect),
    .count     (out_count),
    .head      (out_head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.if_valid       = (out_count != 2'd0);
  assign bus.if_pc          = out_head.pc;
  assign bus.if_instr       = out_head.instr;

endmodule
